// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file micro-op sequencer.
//   - default word / address widths
//   - FSM state encoding (IDLE, EXEC, WRITE, DONE)
//   - 2-bit op codes: ADD, SUB, AND, LOADI
package regfile_seq_pkg;

  localparam int DATA_W_DEF = 2;
  localparam int ADDR_W_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer.
// Ports:
//   op_i      2-bit op code (ADD/SUB/AND/LOADI)
//   a_i, b_i  operands from the two RAM read ports
//   imm_i     immediate for LOADI
//   result_o  DATA_W-bit result, wraps modulo 2**DATA_W
//   carry_o   carry-out for ADD, not-borrow for SUB, 0 otherwise
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        // two's-complement subtract; the top bit is the not-borrow flag
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_AND:   result_o = a_i & b_i;
      default:  result_o = imm_i;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Single-issue micro-op sequencer driving a 2-read/1-write register RAM.
// Accepts an instruction (valid/ready), reads two sources in EXEC,
// registers the ALU result, writes it back in WRITE, then presents it
// downstream in DONE until out_ready.
//
// Optional: define SEQ_OP_COUNT_EN to add op_count, an 8-bit saturating
// count of completed instructions (DONE->IDLE transfers).
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   in_valid/in_ready, in_op/rd/rs1/rs2/imm   instruction input
//   out_valid/out_ready, out_result/out_carry result output
//   Write_*, Read_Address_*        RAM write and read ports
//   Read_Data_1/2                  RAM combinational read data
//
// state | meaning
// IDLE  | ready for an instruction
// EXEC  | sources read, ALU result registered
// WRITE | result written to RAM[rd]
// DONE  | result presented downstream, wait for out_ready
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
`ifdef SEQ_OP_COUNT_EN
  output logic [7:0]        op_count,
`endif
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry,
  output logic [DATA_W-1:0] Write_Data,
  output logic [ADDR_W-1:0] Write_Address,
  output logic              Write_Enable,
  output logic [ADDR_W-1:0] Read_Address_1,
  output logic [ADDR_W-1:0] Read_Address_2,
  input  logic [DATA_W-1:0] Read_Data_1,
  input  logic [DATA_W-1:0] Read_Data_2
);

  seq_state_e state_q, state_d;

  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              accept;

  assign accept = in_valid && (state_q == IDLE);

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op_q),
    .a_i      (Read_Data_1),
    .b_i      (Read_Data_2),
    .imm_i    (imm_q),
    .result_o (alu_result),
    .carry_o  (alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state_q == IDLE);
    out_valid      = (state_q == DONE);
    Write_Enable   = (state_q == WRITE);
    Write_Address  = (state_q == WRITE) ? rd_q : '0;
    Write_Data     = (state_q == WRITE) ? result_q : '0;
    Read_Address_1 = (state_q == EXEC) ? rs1_q : '0;
    Read_Address_2 = (state_q == EXEC) ? rs2_q : '0;
  end

  assign out_result = result_q;
  assign out_carry  = carry_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        imm_q <= in_imm;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        carry_q  <= alu_carry;
      end
    end
  end

`ifdef SEQ_OP_COUNT_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else if (state_q == DONE && out_ready && count_q != 8'hFF)
      count_q <= count_q + 8'd1;
  end

  assign op_count = count_q;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
module tb_regfile_op_sequencer;

  localparam int DW = 2;
  localparam int AW = 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_carry;
  logic [DW-1:0] Write_Data;
  logic [AW-1:0] Write_Address;
  logic          Write_Enable;
  logic [AW-1:0] Read_Address_1, Read_Address_2;
  logic [DW-1:0] Read_Data_1, Read_Data_2;
`ifdef SEQ_OP_COUNT_EN
  logic [7:0]    op_count;
`endif

  regfile_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
`ifdef SEQ_OP_COUNT_EN
    .op_count       (op_count),
`endif
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_rd          (in_rd),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_carry      (out_carry),
    .Write_Data     (Write_Data),
    .Write_Address  (Write_Address),
    .Write_Enable   (Write_Enable),
    .Read_Address_1 (Read_Address_1),
    .Read_Address_2 (Read_Address_2),
    .Read_Data_1    (Read_Data_1),
    .Read_Data_2    (Read_Data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register RAM attached to the DUT: combinational read, posedge write.
  logic [DW-1:0] ram [2];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram[0] <= '0;
      ram[1] <= '0;
    end else if (Write_Enable) begin
      ram[Write_Address] <= Write_Data;
    end
  end
  assign Read_Data_1 = ram[Read_Address_1];
  assign Read_Data_2 = ram[Read_Address_2];

  int we_count;
  always @(posedge clk) if (!reset && Write_Enable) we_count++;

  int checks;
  int errors;
  int model [2];
  int done_total;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model[0] = 0;
    model[1] = 0;
    done_total = 0;
    @(negedge clk);
  endtask

  // Issue one instruction and follow it through EXEC, WRITE and DONE,
  // checking every cycle against the architectural expectation.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                       input int imm, input int stall, input bit busy_valid,
                       input string tag);
    int a, b, s, exp_r, exp_c, we0, held_r;
    a = model[rs1];
    b = model[rs2];
    case (op)
      0: begin s = a + b; exp_r = s % 4; exp_c = (s >= 4) ? 1 : 0; end
      1: begin exp_r = (a - b + 4) % 4; exp_c = (a >= b) ? 1 : 0; end
      2: begin exp_r = a & b; exp_c = 0; end
      default: begin exp_r = imm; exp_c = 0; end
    endcase

    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s.ready_idle got=%b exp=1", tag, in_ready);
    end
    in_valid = 1'b1;
    in_op    = 2'(op);
    in_rd    = AW'(rd);
    in_rs1   = AW'(rs1);
    in_rs2   = AW'(rs2);
    in_imm   = DW'(imm);
    @(posedge clk);
    #1 in_valid = 1'b0;
    we0 = we_count;

    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || Write_Enable !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s.exec got valid=%b we=%b ready=%b exp 0/0/0", tag, out_valid, Write_Enable, in_ready);
    end

    @(negedge clk);
    checks++;
    if (Write_Enable !== 1'b1 || Write_Address !== AW'(rd) || Write_Data !== DW'(exp_r) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s.write got we=%b addr=%0d data=%0d valid=%b exp 1/%0d/%0d/0",
               tag, Write_Enable, Write_Address, Write_Data, out_valid, rd, exp_r);
    end

    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== DW'(exp_r) || out_carry !== exp_c[0] || Write_Enable !== 1'b0) begin
      errors++;
      $display("FAIL %s.done got valid=%b res=%0d carry=%b we=%b exp 1/%0d/%0d/0",
               tag, out_valid, out_result, out_carry, Write_Enable, exp_r, exp_c);
    end
    checks++;
    if (ram[rd] !== DW'(exp_r)) begin
      errors++; $display("FAIL %s.ram got=%0d exp=%0d", tag, ram[rd], exp_r);
    end
    held_r = exp_r;

    if (busy_valid) begin
      in_valid = 1'b1;
      in_op    = 2'(3);
      in_rd    = AW'(rd ^ 1);
      in_imm   = DW'(~held_r);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== DW'(held_r) || in_ready !== 1'b0 || Write_Enable !== 1'b0) begin
        errors++;
        $display("FAIL %s.hold%0d got valid=%b res=%0d ready=%b we=%b exp 1/%0d/0/0",
                 tag, i, out_valid, out_result, in_ready, Write_Enable, held_r);
      end
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (we_count - we0 !== 1) begin
      errors++; $display("FAIL %s.we_pulses got=%0d exp=1", tag, we_count - we0);
    end
    model[rd] = exp_r;
    done_total++;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_carry !== 1'b0 ||
        Write_Enable !== 1'b0 || Write_Data !== '0 || Write_Address !== '0 ||
        Read_Address_1 !== '0 || Read_Address_2 !== '0) begin
      errors++;
      $display("FAIL reset got ready=%b valid=%b res=%0d carry=%b we=%b wd=%0d wa=%0d ra=%0d/%0d exp 1/0/0/0/0/0/0/0/0",
               in_ready, out_valid, out_result, out_carry, Write_Enable, Write_Data, Write_Address,
               Read_Address_1, Read_Address_2);
    end
    reset = 1'b0;
    model[0] = 0;
    model[1] = 0;
    done_total = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    issue(3, 0, 0, 0, 2, 0, 1'b0, "loadi0");
    issue(3, 1, 0, 0, 1, 0, 1'b0, "loadi1");
    issue(0, 0, 0, 1, 0, 0, 1'b0, "add_nocarry");
    issue(0, 1, 0, 0, 0, 0, 1'b0, "add_carry");
    issue(1, 0, 1, 0, 0, 0, 1'b0, "sub_borrow");
    issue(2, 1, 0, 1, 0, 0, 1'b0, "and");
  endtask

  task automatic test_hold();
    issue(1, 1, 0, 0, 0, 5, 1'b1, "hold_busy");
    issue(0, 0, 1, 0, 0, 0, 1'b0, "after_hold");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'(3); in_rd = 1'b1; in_imm = 2'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (Write_Enable !== 1'b1) begin
      errors++; $display("FAIL rstmid.pre_we got=%b exp=1", Write_Enable);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (Write_Enable !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid.async got we=%b valid=%b ready=%b exp 0/0/1", Write_Enable, out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model[0] = 0;
    model[1] = 0;
    done_total = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ram[1] !== '0) begin
      errors++;
      $display("FAIL rstmid.after got ready=%b valid=%b ram1=%0d exp 1/0/0", in_ready, out_valid, ram[1]);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), "rand");
    end
  endtask

`ifdef SEQ_OP_COUNT_EN
  task automatic test_op_count();
    do_reset();
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL opcnt.reset got=%0d exp=0", op_count);
    end
    test_random(3);
    checks++;
    if (op_count !== 8'(done_total)) begin
      errors++; $display("FAIL opcnt.three got=%0d exp=%0d", op_count, done_total);
    end
    test_random(297);
    checks++;
    if (op_count !== 8'((done_total > 255) ? 255 : done_total)) begin
      errors++; $display("FAIL opcnt.saturate got=%0d exp=255", op_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    we_count = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random(60);
`ifdef SEQ_OP_COUNT_EN
    test_op_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
